mult_err_stats: RTL

- Downstream consumer of the registered 5-bit approximate multiplier stage.
- Takes a stream of approximate/exact product pairs and measures error over a fixed window of N_SAMPLES pairs (exhaustive 5x5 sweep = 1024).
- Computes the error distance per pair, then accumulates: sum of error distances, maximum error distance, and count of erroneous results.
- Presents the results through a valid/ready handshake, for on-chip characterisation of approximate multipliers.

---
 rtl/mult_err_stats_pkg.sv | 21 ++
 rtl/mult_err_stats_err_dist.sv | 20 ++
 rtl/mult_err_stats.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mult_err_stats_pkg.sv
// Purpose: shared types and default sizing for the multiplier error-statistics slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding and default widths shared with the multiplier
// test wrappers. CNT_W_DEF is derived so that 2^CNT_W_DEF > N_SAMPLES_DEF.
package mult_err_stats_pkg;

  localparam int W_DEF         = 5;
  localparam int N_SAMPLES_DEF = 1024;                  // exhaustive 5x5 sweep
  localparam int CNT_W_DEF     = $clog2(N_SAMPLES_DEF + 1);
  localparam int SUM_W_DEF     = 16;                    // 1024*31 = 31744 fits

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/mult_err_stats_err_dist.sv
// Purpose: error distance |a-b| and inequality flag between two products.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports: a, b (W-bit unsigned products); ed (W-bit |a-b|); neq (a != b).
module err_dist #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] ed,
  output logic         neq
);

  // Subtract in the order that keeps the result non-negative so the W-bit
  // difference never wraps.
  assign ed  = (a >= b) ? (a - b) : (b - a);
  assign neq = (a != b);

endmodule

// File: rtl/mult_err_stats.sv
// Purpose: accumulates error sum / max / count over a window of appx/exact product pairs.
// Latency: accept -> accumulators after 2 register stages; res_valid 3 cycles after last accept.
// Backpressure: in_ready low outside ACC; res_valid and results held until res_ready.
//
// Ports: clk, rst_n (sync, active-low); start pulse opens a window in IDLE;
// in_valid/in_ready/appx/exact carry the pair stream; busy is high outside IDLE;
// res_valid/res_ready hand over err_sum, err_max, err_cnt and sum_sat.
module mult_err_stats
  import mult_err_stats_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int SUM_W     = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     appx,
  input  logic [W-1:0]     exact,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] err_sum,
  output logic [W-1:0]     err_max,
  output logic [CNT_W-1:0] err_cnt,
  output logic             sum_sat
);

  state_t           state;
  logic [CNT_W-1:0] acc_cnt;

  // Stage-1 pipeline register: distance and inequality of the accepted pair.
  logic             s1_vld;
  logic [W-1:0]     s1_ed;
  logic             s1_neq;

  logic [W-1:0]     ed;
  logic             neq;
  logic             accept;
  logic             last_accept;
  logic [SUM_W:0]   sum_ext;

  err_dist #(.W(W)) u_err_dist (
    .a   (appx),
    .b   (exact),
    .ed  (ed),
    .neq (neq)
  );

  assign accept      = in_valid & in_ready;
  assign last_accept = accept && (acc_cnt == CNT_W'(N_SAMPLES - 1));

  // One extra bit catches the carry out so the sum can clamp instead of wrap.
  assign sum_ext = {1'b0, err_sum} + (SUM_W + 1)'(s1_ed);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_cnt   <= '0;
      s1_vld    <= 1'b0;
      s1_ed     <= '0;
      s1_neq    <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      err_sum   <= '0;
      err_max   <= '0;
      err_cnt   <= '0;
      sum_sat   <= 1'b0;
    end else begin
      s1_vld <= accept;
      s1_ed  <= ed;
      s1_neq <= neq;

      // Stage 2: fold the registered distance into the window statistics.
      if (s1_vld) begin
        if (sum_ext[SUM_W]) begin
          err_sum <= '1;
          sum_sat <= 1'b1;
        end else begin
          err_sum <= sum_ext[SUM_W-1:0];
        end
        if (s1_ed > err_max) err_max <= s1_ed;
        err_cnt <= err_cnt + CNT_W'(s1_neq);
      end

      // The FSM comes after the accumulate so the start-time clear has priority;
      // the pipeline is always empty in IDLE, so the two never really collide.
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACC;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            acc_cnt  <= '0;
            err_sum  <= '0;
            err_max  <= '0;
            err_cnt  <= '0;
            sum_sat  <= 1'b0;
          end
        end
        ACC: begin
          if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (last_accept) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The final pair is in stage 1 on the first DRAIN cycle; once stage 1
          // is empty the accumulators already hold the complete window.
          if (!s1_vld) begin
            state     <= REPORT;
            res_valid <= 1'b1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
